// File: rtl/seq_multiplier_if.sv
// Handshake and operand/result bundle for seq_multiplier.
// The master drives the request; the slave (the multiplier) returns status and the product.
interface seq_multiplier_if #(parameter int WIDTH = 4);
   logic                 start;
   logic                 signed_mode;
   logic [WIDTH-1:0]     m;
   logic [WIDTH-1:0]     q;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;

   modport master (
      output start, signed_mode, m, q,
      input  busy, done, product
   );

   modport slave (
      input  start, signed_mode, m, q,
      output busy, done, product
   );
endinterface

// File: rtl/seq_multiplier.sv
// Shift-and-add multiplier, one partial product per clock, with optional two's complement mode.
// Signed operands are multiplied as magnitudes and the sign is re-applied in FIX.
module seq_multiplier #(
   parameter int WIDTH = 4
) (
   input  logic           clk,
   input  logic           rst,
   seq_multiplier_if.slave bus
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t               state;
   logic [WIDTH-1:0]     mcand;
   logic [WIDTH-1:0]     mplier;
   logic [2*WIDTH-1:0]   acc;
   logic [CW-1:0]        cnt;
   logic                 neg;

   logic [WIDTH-1:0]     m_abs;
   logic [WIDTH-1:0]     q_abs;
   logic [WIDTH:0]       sum;

   // The most-negative operand negates to itself, which reads correctly as an unsigned magnitude.
   always_comb begin
      m_abs = bus.m;
      q_abs = bus.q;
      if (bus.signed_mode && bus.m[WIDTH-1]) m_abs = -bus.m;
      if (bus.signed_mode && bus.q[WIDTH-1]) q_abs = -bus.q;
      sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand & {WIDTH{mplier[0]}}};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         mcand       <= '0;
         mplier      <= '0;
         acc         <= '0;
         cnt         <= '0;
         neg         <= 1'b0;
         bus.busy    <= 1'b0;
         bus.done    <= 1'b0;
         bus.product <= '0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  mcand    <= m_abs;
                  mplier   <= q_abs;
                  neg      <= bus.signed_mode & (bus.m[WIDTH-1] ^ bus.q[WIDTH-1]);
                  acc      <= '0;
                  cnt      <= '0;
                  bus.busy <= 1'b1;
                  state    <= CALC;
               end
            end
            CALC: begin
               // Carry from the add becomes the new MSB as the whole accumulator shifts right.
               acc    <= {sum, acc[WIDTH-1:1]};
               mplier <= mplier >> 1;
               cnt    <= cnt + CW'(1);
               if (cnt == CW'(WIDTH - 1)) state <= FIX;
            end
            FIX: begin
               bus.product <= neg ? -acc : acc;
               bus.busy    <= 1'b0;
               bus.done    <= 1'b1;
               state       <= DONE;
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier at WIDTH=4 and WIDTH=8.
// Expected products come from integer multiplication of the sign- or zero-extended operands.
module tb_seq_multiplier;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   seq_multiplier_if #(.WIDTH(4)) bus4 ();
   seq_multiplier_if #(.WIDTH(8)) bus8 ();

   seq_multiplier #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .bus(bus4));
   seq_multiplier #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .bus(bus8));

   int passed = 0;
   int total  = 0;
   logic [63:0] sb4[$];
   logic [63:0] sb8[$];

   function automatic logic [63:0] model(input int w, input logic sm,
                                         input logic [31:0] a, input logic [31:0] b);
      longint x, y, r;
      x = longint'(a) & ((longint'(1) << w) - 1);
      y = longint'(b) & ((longint'(1) << w) - 1);
      if (sm && x[w-1]) x = x - (longint'(1) << w);
      if (sm && y[w-1]) y = y - (longint'(1) << w);
      r = x * y;
      return r & ((longint'(1) << (2*w)) - 1);
   endfunction

   task automatic start4(input logic sm, input logic [3:0] a, input logic [3:0] b);
      @(negedge clk);
      bus4.start = 1'b1; bus4.signed_mode = sm; bus4.m = a; bus4.q = b;
      sb4.push_back(model(4, sm, {28'd0, a}, {28'd0, b}));
   endtask

   task automatic start8(input logic sm, input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      bus8.start = 1'b1; bus8.signed_mode = sm; bus8.m = a; bus8.q = b;
      sb8.push_back(model(8, sm, {24'd0, a}, {24'd0, b}));
   endtask

   // cyc = negedges from the start-driving negedge to the one showing done; -1 on timeout
   task automatic wait4(output int cyc, output int bc);
      bit found = 0;
      cyc = 0; bc = 0;
      while (!found && cyc < 40) begin
         @(negedge clk);
         bus4.start = 1'b0;
         cyc++;
         if (bus4.busy) bc++;
         if (bus4.done) found = 1;
      end
      if (!found) cyc = -1;
   endtask

   task automatic wait8(output int cyc, output int bc);
      bit found = 0;
      cyc = 0; bc = 0;
      while (!found && cyc < 40) begin
         @(negedge clk);
         bus8.start = 1'b0;
         cyc++;
         if (bus8.busy) bc++;
         if (bus8.done) found = 1;
      end
      if (!found) cyc = -1;
   endtask

   task automatic op4(input logic sm, input logic [3:0] a, input logic [3:0] b,
                      output int cyc, output int bc, output logic [7:0] got, output logic [7:0] exp);
      logic [63:0] e;
      start4(sm, a, b);
      wait4(cyc, bc);
      e   = sb4.pop_front();
      exp = e[7:0];
      got = bus4.product;
   endtask

   task automatic op8(input logic sm, input logic [7:0] a, input logic [7:0] b,
                      output int cyc, output int bc, output logic [15:0] got, output logic [15:0] exp);
      logic [63:0] e;
      start8(sm, a, b);
      wait8(cyc, bc);
      e   = sb8.pop_front();
      exp = e[15:0];
      got = bus8.product;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      bus4.start = 1'b0; bus4.signed_mode = 1'b0; bus4.m = '0; bus4.q = '0;
      bus8.start = 1'b0; bus8.signed_mode = 1'b0; bus8.m = '0; bus8.q = '0;
      #1 rst = 1'b1;
      #2;
      total++;
      if (bus4.busy !== 1'b0 || bus4.done !== 1'b0 || bus4.product !== 8'h00) begin
         $display("FAIL reset_w4: busy=%b done=%b product=%h, need 0 0 00", bus4.busy, bus4.done, bus4.product);
      end else passed++;
      total++;
      if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus8.product !== 16'h0000) begin
         $display("FAIL reset_w8: busy=%b done=%b product=%h, need 0 0 0000", bus8.busy, bus8.done, bus8.product);
      end else passed++;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_unsigned;
      int c, b; logic [7:0] got, exp;
      op4(1'b0, 4'd15, 4'd15, c, b, got, exp);
      total++;
      if (c !== 6) $display("FAIL unsigned_latency: cycles=%0d need 6", c); else passed++;
      total++;
      if (b !== 5) $display("FAIL unsigned_busy: busy_cycles=%0d need 5", b); else passed++;
      total++;
      if (got !== exp) $display("FAIL unsigned_product: got=%h need %h", got, exp); else passed++;
      @(negedge clk);
      total++;
      if (bus4.done !== 1'b0) $display("FAIL done_width: done=%b need 0", bus4.done); else passed++;
   endtask

   task automatic test_signed;
      logic [3:0] ta [3] = '{4'h8, 4'hD, 4'h7};
      logic [3:0] tb [3] = '{4'h8, 4'h5, 4'h8};
      int c, b; logic [7:0] got, exp;
      for (int i = 0; i < 3; i++) begin
         op4(1'b1, ta[i], tb[i], c, b, got, exp);
         total++;
         if (c !== 6) $display("FAIL signed_latency[%0d]: cycles=%0d need 6", i, c); else passed++;
         total++;
         if (got !== exp) $display("FAIL signed_product[%0d]: got=%h need %h", i, got, exp); else passed++;
      end
   endtask

   task automatic test_start_ignored;
      int c = 0, b; bit found = 0; logic [63:0] e;
      @(negedge clk);
      bus4.start = 1'b1; bus4.signed_mode = 1'b0; bus4.m = 4'd3; bus4.q = 4'd2;
      sb4.push_back(model(4, 1'b0, 32'd3, 32'd2));
      while (!found && c < 40) begin
         @(negedge clk);
         c++;
         if (c == 2) bus4.m = 4'd9;
         if (bus4.done) found = 1;
      end
      e = sb4.pop_front();
      total++;
      if (c !== 6) $display("FAIL hold_start_latency: cycles=%0d need 6", c); else passed++;
      total++;
      if (bus4.product !== e[7:0]) $display("FAIL hold_start_product: got=%h need %h", bus4.product, e[7:0]); else passed++;
      // still held high: ignored in DONE, accepted once back in IDLE
      sb4.push_back(model(4, 1'b0, 32'd9, 32'd2));
      @(negedge clk);
      total++;
      if (bus4.busy !== 1'b0) $display("FAIL start_in_done: busy=%b need 0", bus4.busy); else passed++;
      @(negedge clk);
      total++;
      if (bus4.busy !== 1'b1) $display("FAIL start_in_idle: busy=%b need 1", bus4.busy); else passed++;
      bus4.start = 1'b0;
      wait4(c, b);
      e = sb4.pop_front();
      total++;
      if (c < 0 || bus4.product !== e[7:0]) $display("FAIL restart_product: got=%h cycles=%0d need %h", bus4.product, c, e[7:0]);
      else passed++;
   endtask

   task automatic test_reset_mid;
      int c, b; logic [7:0] got, exp;
      start4(1'b0, 4'd13, 4'd11);
      @(negedge clk);
      bus4.start = 1'b0;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      void'(sb4.pop_back());
      total++;
      if (bus4.busy !== 1'b0 || bus4.done !== 1'b0 || bus4.product !== 8'h00)
         $display("FAIL reset_mid: busy=%b done=%b product=%h need 0 0 00", bus4.busy, bus4.done, bus4.product);
      else passed++;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (bus4.busy !== 1'b0 || bus4.done !== 1'b0) $display("FAIL post_reset_idle: busy=%b done=%b need 0 0", bus4.busy, bus4.done);
      else passed++;
      op4(1'b0, 4'd5, 4'd3, c, b, got, exp);
      total++;
      if (c !== 6 || got !== exp) $display("FAIL post_reset_op: got=%h cycles=%0d need %h in 6", got, c, exp); else passed++;
   endtask

   task automatic test_zero_hold;
      int c, b; logic [7:0] got, exp;
      op4(1'b0, 4'd0, 4'd11, c, b, got, exp);
      total++;
      if (c !== 6 || b !== 5) $display("FAIL zero_latency: cycles=%0d busy=%0d need 6 5", c, b); else passed++;
      total++;
      if (got !== exp) $display("FAIL zero_product: got=%h need %h", got, exp); else passed++;
      op4(1'b1, 4'd3, 4'hE, c, b, got, exp);
      total++;
      if (got !== exp) $display("FAIL neg_product: got=%h need %h", got, exp); else passed++;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         total++;
         if (bus4.product !== exp || bus4.done !== 1'b0)
            $display("FAIL hold[%0d]: product=%h done=%b need %h 0", i, bus4.product, bus4.done, exp);
         else passed++;
      end
   endtask

   task automatic test_wide;
      int c, b; logic [15:0] got, exp;
      op8(1'b0, 8'hFF, 8'hFF, c, b, got, exp);
      total++;
      if (c !== 10 || b !== 9) $display("FAIL w8_latency: cycles=%0d busy=%0d need 10 9", c, b); else passed++;
      total++;
      if (got !== exp) $display("FAIL w8_unsigned: got=%h need %h", got, exp); else passed++;
      op8(1'b1, 8'h80, 8'h01, c, b, got, exp);
      total++;
      if (got !== exp) $display("FAIL w8_signed: got=%h need %h", got, exp); else passed++;
   endtask

   task automatic test_back_to_back;
      int c, b; logic [7:0] g4, e4; logic [15:0] g8, e8;
      for (int i = 0; i < 6; i++) begin
         op4(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), c, b, g4, e4);
         total++;
         if (c !== 6 || g4 !== e4) $display("FAIL b2b_w4[%0d]: got=%h cycles=%0d need %h in 6", i, g4, c, e4); else passed++;
      end
      for (int i = 0; i < 6; i++) begin
         op8(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), c, b, g8, e8);
         total++;
         if (c !== 10 || g8 !== e8) $display("FAIL b2b_w8[%0d]: got=%h cycles=%0d need %h in 10", i, g8, c, e8); else passed++;
      end
   endtask

   initial begin
      test_reset;
      test_unsigned;
      test_signed;
      test_start_ignored;
      test_reset_mid;
      test_zero_hold;
      test_wide;
      test_back_to_back;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
